// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared definitions for the push-button debouncer family.
//   - deb_state_e : per-channel debounce state (LOW, RISING, HIGH, FALLING)
//   - cnt_width   : counter width able to hold values 0..n, i.e. clog2(n+1)
// -----------------------------------------------------------------------------
package debounce_pkg;

   typedef enum logic [1:0] {
      ST_LOW     = 2'b00,  // clean = 0, input agrees
      ST_RISING  = 2'b01,  // clean = 0, counting toward 1
      ST_HIGH    = 2'b10,  // clean = 1, input agrees
      ST_FALLING = 2'b11   // clean = 1, counting toward 0
   } deb_state_e;

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One debounce channel: SYNC_STAGES-deep synchroniser, stability counter
//   with a four-state FSM, registered press/release pulses and an optional
//   long-press detector.
//
// Ports
//   clock        in  system clock, all state on rising edge
//   reset        in  synchronous active-high reset
//   button_i     in  raw asynchronous input
//   clean_o      out debounced level
//   press_o      out one-cycle pulse in the first cycle clean_o reads 1
//   release_o    out one-cycle pulse in the first cycle clean_o reads 0
//   long_press_o out one-cycle pulse once clean_o has been high LONG_CYCLES
//                    cycles; constant 0 when LONG_CYCLES == 0
// -----------------------------------------------------------------------------
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 1000000,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned LONG_CYCLES   = 50000000
) (
   input  logic clock,
   input  logic reset,
   input  logic button_i,
   output logic clean_o,
   output logic press_o,
   output logic release_o,
   output logic long_press_o
);

   localparam int unsigned    CW   = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0]  TERM = CW'(STABLE_CYCLES - 1);

   // ---------------------------------------------------------------------
   // Synchroniser
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], button_i};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------------
   // Debounce FSM and stability counter
   // ---------------------------------------------------------------------
   deb_state_e     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           press_q, press_d;
   logic           release_q, release_d;
   logic           clean;

   assign clean = (state_q == ST_HIGH) || (state_q == ST_FALLING);

   // Leaving LOW/HIGH already counts the first disagreeing cycle, so the
   // counter holds 1 on entry to RISING/FALLING. This matches a plain
   // "count while s != clean" counter cycle for cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
         ST_LOW: begin
            if (s) begin
               state_d = ST_RISING;
               cnt_d   = CW'(1);
            end
         end
         ST_RISING: begin
            if (!s) begin
               state_d = ST_LOW;
            end else if (cnt_q == TERM) begin
               state_d = ST_HIGH;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_HIGH: begin
            if (!s) begin
               state_d = ST_FALLING;
               cnt_d   = CW'(1);
            end
         end
         ST_FALLING: begin
            if (s) begin
               state_d = ST_HIGH;
            end else if (cnt_q == TERM) begin
               state_d   = ST_LOW;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_LOW;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_LOW;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign clean_o   = clean;
   assign press_o   = press_q;
   assign release_o = release_q;

   // ---------------------------------------------------------------------
   // Long-press detector
   // ---------------------------------------------------------------------
   generate
      if (LONG_CYCLES > 0) begin : g_long
         localparam int unsigned   HW       = cnt_width(LONG_CYCLES);
         localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

         logic [HW-1:0] hold_q, hold_d;
         logic          long_q, long_d;

         // Only clean == 0 clears the hold count, so a bounce that parks
         // the FSM in FALLING cannot re-arm the pulse; saturation makes it
         // fire at most once per press.
         always_comb begin
            hold_d = hold_q;
            long_d = 1'b0;
            if (!clean) begin
               hold_d = '0;
            end else if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + HW'(1);
               long_d = (hold_q == (HOLD_MAX - HW'(1)));
            end
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               hold_q <= '0;
               long_q <= 1'b0;
            end else begin
               hold_q <= hold_d;
               long_q <= long_d;
            end
         end

         assign long_press_o = long_q;
      end else begin : g_no_long
         assign long_press_o = 1'b0;
      end
   endgenerate

endmodule : debounce_channel

// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
//   CHANNELS independent debounce channels sharing only clock and reset.
//
// Ports (bit i belongs to channel i)
//   clock        in  system clock
//   reset        in  synchronous active-high reset
//   button_i     in  raw asynchronous button/switch inputs
//   clean_o      out debounced levels
//   press_o      out one-cycle pulses on clean rise
//   release_o    out one-cycle pulses on clean fall ("release" alone is a
//                    reserved word, hence the suffixed names)
//   long_press_o out one-cycle long-press pulses
// -----------------------------------------------------------------------------
module multi_debouncer #(
   parameter int unsigned CHANNELS      = 4,
   parameter int unsigned STABLE_CYCLES = 1000000,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned LONG_CYCLES   = 50000000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] button_i,
   output logic [CHANNELS-1:0] clean_o,
   output logic [CHANNELS-1:0] press_o,
   output logic [CHANNELS-1:0] release_o,
   output logic [CHANNELS-1:0] long_press_o
);

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
         debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .LONG_CYCLES   (LONG_CYCLES)
         ) u_channel (
            .clock        (clock),
            .reset        (reset),
            .button_i     (button_i[i]),
            .clean_o      (clean_o[i]),
            .press_o      (press_o[i]),
            .release_o    (release_o[i]),
            .long_press_o (long_press_o[i])
         );
      end
   endgenerate

endmodule : multi_debouncer

// File: tb/tb_multi_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_debouncer
//   Directed self-checking bench for multi_debouncer with CHANNELS=4,
//   STABLE_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=10 (clean follows the input
//   6 edges after the edge preceding an input change).
// -----------------------------------------------------------------------------
module tb_multi_debouncer;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] button;
   logic [3:0] clean;
   logic [3:0] press;
   logic [3:0] rel;
   logic [3:0] lp;

   int checks = 0;
   int errors = 0;

   multi_debouncer #(
      .CHANNELS      (4),
      .STABLE_CYCLES (4),
      .SYNC_STAGES   (2),
      .LONG_CYCLES   (10)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .button_i     (button),
      .clean_o      (clean),
      .press_o      (press),
      .release_o    (rel),
      .long_press_o (lp)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      button = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({clean, press, rel, lp} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs cyc%0d: got %h expected 0000", i, {clean, press, rel, lp});
         end
      end
      reset = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if ({clean, press} !== 8'h00) begin
            errors++;
            $display("FAIL held_through_reset_early cyc%0d: clean/press got %b_%b expected 0000_0000", i, clean, press);
         end
      end
      tick();
      checks++;
      if (clean !== 4'b1111 || press !== 4'b1111) begin
         errors++;
         $display("FAIL held_through_reset_rise: clean/press got %b_%b expected 1111_1111", clean, press);
      end
      tick();
      checks++;
      if (clean !== 4'b1111 || press !== 4'b0000) begin
         errors++;
         $display("FAIL press_width_all: clean/press got %b_%b expected 1111_0000", clean, press);
      end
      button = 4'b0000;
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (clean !== 4'b1111 || rel !== 4'b0000) begin
            errors++;
            $display("FAIL release_all_early cyc%0d: clean/release got %b_%b expected 1111_0000", i, clean, rel);
         end
      end
      tick();
      checks++;
      if (clean !== 4'b0000 || rel !== 4'b1111) begin
         errors++;
         $display("FAIL release_all_fall: clean/release got %b_%b expected 0000_1111", clean, rel);
      end
      tick();
      checks++;
      if (rel !== 4'b0000 || lp !== 4'b0000) begin
         errors++;
         $display("FAIL release_all_after: release/long got %b_%b expected 0000_0000", rel, lp);
      end
   endtask

   task automatic test_single_press();
      button[0] = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (clean !== 4'b0000 || press !== 4'b0000) begin
            errors++;
            $display("FAIL single_early cyc%0d: clean/press got %b_%b expected 0000_0000", i, clean, press);
         end
      end
      tick();
      checks++;
      if (clean !== 4'b0001 || press !== 4'b0001 || rel !== 4'b0000) begin
         errors++;
         $display("FAIL single_rise: clean/press/release got %b_%b_%b expected 0001_0001_0000", clean, press, rel);
      end
      tick();
      checks++;
      if (clean !== 4'b0001 || press !== 4'b0000) begin
         errors++;
         $display("FAIL single_after: clean/press got %b_%b expected 0001_0000", clean, press);
      end
   endtask

   task automatic test_bounce();
      for (int r = 0; r < 5; r++) begin
         for (int j = 0; j < 4; j++) begin
            button[1] = (j < 3);
            tick();
            checks++;
            if (clean[1] !== 1'b0 || press[1] !== 1'b0) begin
               errors++;
               $display("FAIL bounce_filtered rep%0d ph%0d: clean1/press1 got %b%b expected 00", r, j, clean[1], press[1]);
            end
         end
      end
      button[1] = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (clean[1] !== 1'b0 || press[1] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_settle_early cyc%0d: clean1/press1 got %b%b expected 00", i, clean[1], press[1]);
         end
      end
      tick();
      checks++;
      if (clean[1] !== 1'b1 || press[1] !== 1'b1) begin
         errors++;
         $display("FAIL bounce_rise: clean1/press1 got %b%b expected 11", clean[1], press[1]);
      end
      tick();
      checks++;
      if (clean[1] !== 1'b1 || press[1] !== 1'b0) begin
         errors++;
         $display("FAIL bounce_single_press: clean1/press1 got %b%b expected 10", clean[1], press[1]);
      end
   endtask

   task automatic test_long_press();
      button[2] = 1'b1;
      for (int i = 1; i <= 5; i++) tick();
      tick();
      checks++;
      if (clean[2] !== 1'b1 || press[2] !== 1'b1) begin
         errors++;
         $display("FAIL long_rise: clean2/press2 got %b%b expected 11", clean[2], press[2]);
      end
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++;
         if (lp[2] !== (k == 10)) begin
            errors++;
            $display("FAIL long_pulse cyc%0d: long2 got %b expected %b", k, lp[2], (k == 10));
         end
      end
      button[2] = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (clean[2] !== 1'b1 || rel[2] !== 1'b0 || lp[2] !== 1'b0) begin
            errors++;
            $display("FAIL long_release_early cyc%0d: clean2/rel2/long2 got %b%b%b expected 100", i, clean[2], rel[2], lp[2]);
         end
      end
      tick();
      checks++;
      if (clean[2] !== 1'b0 || rel[2] !== 1'b1) begin
         errors++;
         $display("FAIL long_release_fall: clean2/rel2 got %b%b expected 01", clean[2], rel[2]);
      end
      tick();
      checks++;
      if (rel[2] !== 1'b0) begin
         errors++;
         $display("FAIL long_release_width: rel2 got %b expected 0", rel[2]);
      end
   endtask

   task automatic test_reset_mid_count();
      button[3] = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (clean[3] !== 1'b0) begin
            errors++;
            $display("FAIL midcount_pre cyc%0d: clean3 got %b expected 0", i, clean[3]);
         end
      end
      reset = 1'b1;
      tick();
      checks++;
      if ({clean, press, rel, lp} !== 16'h0000) begin
         errors++;
         $display("FAIL midcount_reset: outputs got %h expected 0000", {clean, press, rel, lp});
      end
      reset = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (clean !== 4'b0000) begin
            errors++;
            $display("FAIL midcount_restart cyc%0d: clean got %b expected 0000", i, clean);
         end
      end
      tick();
      checks++;
      if (clean !== 4'b1011 || press !== 4'b1011) begin
         errors++;
         $display("FAIL midcount_rise: clean/press got %b_%b expected 1011_1011", clean, press);
      end
      tick();
      checks++;
      if (press !== 4'b0000) begin
         errors++;
         $display("FAIL midcount_after: press got %b expected 0000", press);
      end
   endtask

   task automatic test_simultaneous();
      button = 4'b1001;
      for (int i = 1; i <= 5; i++) tick();
      tick();
      checks++;
      if (clean !== 4'b1001 || rel !== 4'b0010) begin
         errors++;
         $display("FAIL simul_prep: clean/release got %b_%b expected 1001_0010", clean, rel);
      end
      tick();
      tick();
      button = 4'b1010;
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (press !== 4'b0000 || rel !== 4'b0000) begin
            errors++;
            $display("FAIL simul_early cyc%0d: press/release got %b_%b expected 0000_0000", i, press, rel);
         end
      end
      tick();
      checks++;
      if (clean !== 4'b1010 || press !== 4'b0010 || rel !== 4'b0001) begin
         errors++;
         $display("FAIL simul_edge: clean/press/release got %b_%b_%b expected 1010_0010_0001", clean, press, rel);
      end
      tick();
      checks++;
      if (press !== 4'b0000 || rel !== 4'b0000) begin
         errors++;
         $display("FAIL simul_after: press/release got %b_%b expected 0000_0000", press, rel);
      end
   endtask

   initial begin
      reset  = 1'b1;
      button = 4'b0000;
      test_reset();
      test_single_press();
      test_bounce();
      test_long_press();
      test_reset_mid_count();
      test_simultaneous();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_multi_debouncer

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised, multi-channel successor to the single-button debouncer.
- Each channel synchronises a raw mechanical input into the clock domain and filters bounce with a stability counter.
- Each channel produces a clean level plus one-cycle press, release and long-press pulses.
- Sits between board push-buttons/switches and counter/control logic, replacing per-button debouncer instances.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- STABLE_CYCLES, 1000000, cycles the synchronised input must differ from clean before clean follows (>=2; 10 ms at 100 MHz).
- SYNC_STAGES, 2, flip-flop synchroniser depth per channel (>=2).
- LONG_CYCLES, 50000000, cycles clean must stay high before long_press fires; 0 disables long_press.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- button  in  CHANNELS  raw asynchronous inputs, bit i = channel i.
- clean  out  CHANNELS  debounced level per channel.
- press  out  CHANNELS  one-cycle pulse when clean rises.
- release  out  CHANNELS  one-cycle pulse when clean falls.
- long_press  out  CHANNELS  one-cycle pulse, at most once per press.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; ports are named clock and reset.
- Reset values: all synchroniser flops, counters, clean, press, release and long_press are 0. Reset overrides everything, including a mid-count.
- Channel independence: channels are fully independent; no shared state beyond clock and reset.
- Synchroniser: s_i = button[i] delayed through SYNC_STAGES flops.
- Stability counter: cnt, width $clog2(STABLE_CYCLES+1).
  - If s_i == clean[i], cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1: clean[i] <= s_i and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any return of s_i to clean[i] before the terminal count restarts the count from 0.
- Latency: a clean step on button[i], held, changes clean[i] exactly SYNC_STAGES+STABLE_CYCLES cycles after the first edge where button[i] is sampled at its new value.
- Pulses:
  - press[i] is registered and high in the same cycle clean[i] first reads 1; release[i] likewise when clean[i] first reads 0.
  - Each is exactly one cycle wide.
  - press and release never assert together on one channel.
- Per-channel state machine: LOW, RISING (counting toward 1), HIGH, FALLING (counting toward 0).
  - LOW -> RISING on s=1.
  - RISING -> LOW on s=0.
  - RISING -> HIGH at terminal count.
  - HIGH and FALLING are symmetric.
  - clean = 1 in HIGH and FALLING.
- Long press (LONG_CYCLES > 0):
  - hold counter, width $clog2(LONG_CYCLES+1), cleared while clean[i]=0.
  - Increments while clean[i]=1 and saturates at LONG_CYCLES.
  - long_press[i] is high for the single cycle in which the counter transitions to LONG_CYCLES, i.e. the cycle clean has been high LONG_CYCLES cycles.
  - FALLING does not clear the hold counter; only clean=0 does. A bounce inside a held press does not re-arm long_press.
- Long press disabled (LONG_CYCLES == 0): long_press is constant 0 and no hold counter is generated.
- Boundary cases:
  - Input held through reset: after reset deasserts, clean rises SYNC_STAGES+STABLE_CYCLES cycles later, with a press pulse.
  - A glitch shorter than STABLE_CYCLES never reaches clean.
  - Counters never wrap, because the terminal compare precedes overflow.

Decomposition:
- Package debounce_pkg: the state encoding (LOW, RISING, HIGH, FALLING, 2 bits) and a width helper function (clog2 of N+1) used for both counters.
- Sub-module debounce_channel: one channel (synchroniser, stability counter, FSM, pulse and long-press logic).
  - Same parameters except CHANNELS.
  - Ports clock, reset, button, clean, press, release, long_press, all 1 bit.
- multi_debouncer instantiates CHANNELS copies in a generate loop.

Test Plan (CHANNELS=4, STABLE_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=10, 10 ns clock):
1. Reset 3 cycles with button=4'b1111 -> all outputs 0 during reset; clean=4'b1111 exactly 6 cycles after deassert, press=4'b1111 for one cycle.
2. Button[0] 0->1 and held -> clean[0]=1 exactly 6 cycles after the sampling edge; press[0] high 1 cycle; other channels unchanged.
3. Button[1] bounce (high 3 cycles, low 1, repeated 5 times), then steady high -> clean[1] stays 0 through the bounce, rises 6 cycles after the final rising edge, single press pulse.
4. Button[2] held high 20 cycles after clean rise -> long_press[2] one pulse 10 cycles after clean[2] rose, no second pulse; then release -> clean[2] falls 6 cycles later, release[2] one pulse.
5. Button[3] high for 3 cycles, then reset asserted 1 cycle while still high -> clean[3] stays 0, count restarts; clean[3] rises 6 cycles after reset deasserts.
6. Simultaneous: button[0] falls while button[1] rises on the same edge -> release[0] and press[1] pulse in the same cycle, 6 cycles later.
